dsi_lane_sequencer: RTL

DSI_LANE_SEQUENCER -- requirements
Module: dsi_lane_sequencer

---
 rtl/dsi_lane_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/dsi_lane_sequencer.sv
// Single-lane DSI HS burst sequencer: LP-11 -> LP-01 -> LP-00 -> HS-zero -> sync -> data -> trail -> LP-11.
// Define DSI_LANE_SEQ_STATS_EN to enable the completed-packet counter on pkt_count_o.
module dsi_lane_sequencer #(
   parameter int g_tlpx        = 2,
   parameter int g_ths_prepare = 3,
   parameter int g_ths_zero    = 5,
   parameter int g_ths_trail   = 4
) (
   input  logic        clk_dsi_i,
   input  logic        rst_i,
   input  logic        tx_valid_i,
   input  logic [7:0]  tx_data_i,
   input  logic        tx_last_i,
   output logic        tx_ready_o,
   output logic [7:0]  serdes_data_o,
   output logic        serdes_oe_o,
   output logic        lp_p_o,
   output logic        lp_n_o,
   output logic        lp_oe_o,
   output logic        busy_o,
   output logic        underrun_o,
   output logic [15:0] pkt_count_o
);

   localparam int MAX_A = (g_tlpx > g_ths_prepare) ? g_tlpx : g_ths_prepare;
   localparam int MAX_B = (g_ths_zero > g_ths_trail) ? g_ths_zero : g_ths_trail;
   localparam int MAXD  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CW    = $clog2(MAXD) + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_LP01, S_LP00, S_HS_ZERO, S_SYNC, S_DATA, S_TRAIL, S_EXIT
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          last_pend_q, last_pend_d;
   logic [7:0]    serdes_data_q, serdes_data_d;
   logic          serdes_oe_q, serdes_oe_d;
   logic          lp_p_q, lp_p_d, lp_n_q, lp_n_d, lp_oe_q, lp_oe_d;
   logic          busy_q, busy_d, underrun_q, underrun_d;
   logic          cnt_zero;

   // A byte whose tx_last_i was taken closes the window even while it is still on the lane.
   assign tx_ready_o = tx_valid_i & ~rst_i &
                       ((state_q == S_SYNC) | ((state_q == S_DATA) & ~last_pend_q));
   assign cnt_zero   = (cnt_q == '0);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_zero ? cnt_q : cnt_q - 1'b1;
      last_pend_d = last_pend_q;
      underrun_d  = 1'b0;
      case (state_q)
         S_IDLE:    if (tx_valid_i) begin state_d = S_LP01; cnt_d = CW'(g_tlpx - 1); end
         S_LP01:    if (cnt_zero) begin state_d = S_LP00; cnt_d = CW'(g_ths_prepare - 1); end
         S_LP00:    if (cnt_zero) begin state_d = S_HS_ZERO; cnt_d = CW'(g_ths_zero - 1); end
         S_HS_ZERO: if (cnt_zero) state_d = S_SYNC;
         S_SYNC, S_DATA: begin
            if (tx_ready_o) begin
               state_d     = S_DATA;
               last_pend_d = tx_last_i;
            end else begin
               state_d     = S_TRAIL;
               cnt_d       = CW'(g_ths_trail - 1);
               last_pend_d = 1'b0;
               underrun_d  = ~last_pend_q;
            end
         end
         S_TRAIL:   if (cnt_zero) begin state_d = S_EXIT; cnt_d = CW'(g_tlpx - 1); end
         S_EXIT:    if (cnt_zero) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase

      serdes_data_d = 8'h00;
      serdes_oe_d   = 1'b1;
      lp_oe_d       = 1'b0;
      lp_p_d        = 1'b0;
      lp_n_d        = 1'b0;
      busy_d        = (state_d != S_IDLE);
      case (state_d)
         S_IDLE, S_EXIT: begin serdes_oe_d = 1'b0; lp_oe_d = 1'b1; lp_p_d = 1'b1; lp_n_d = 1'b1; end
         S_LP01:         begin serdes_oe_d = 1'b0; lp_oe_d = 1'b1; lp_n_d = 1'b1; end
         S_LP00:         begin serdes_oe_d = 1'b0; lp_oe_d = 1'b1; end
         S_SYNC:         serdes_data_d = 8'hB8;
         S_DATA:         serdes_data_d = tx_data_i;
         // Trail level is the inverse of the final bit driven before the burst ended.
         S_TRAIL:        serdes_data_d = (state_q == S_TRAIL) ? serdes_data_q
                                                              : {8{~serdes_data_q[7]}};
         default:        serdes_data_d = 8'h00;
      endcase
   end

   always_ff @(posedge clk_dsi_i) begin
      if (rst_i) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         last_pend_q   <= 1'b0;
         serdes_data_q <= 8'h00;
         serdes_oe_q   <= 1'b0;
         lp_p_q        <= 1'b1;
         lp_n_q        <= 1'b1;
         lp_oe_q       <= 1'b1;
         busy_q        <= 1'b0;
         underrun_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         last_pend_q   <= last_pend_d;
         serdes_data_q <= serdes_data_d;
         serdes_oe_q   <= serdes_oe_d;
         lp_p_q        <= lp_p_d;
         lp_n_q        <= lp_n_d;
         lp_oe_q       <= lp_oe_d;
         busy_q        <= busy_d;
         underrun_q    <= underrun_d;
      end
   end

`ifdef DSI_LANE_SEQ_STATS_EN
   logic [15:0] pkt_count_q;
   always_ff @(posedge clk_dsi_i) begin
      if (rst_i)
         pkt_count_q <= 16'h0000;
      else if ((state_d == S_TRAIL) && (state_q != S_TRAIL))
         pkt_count_q <= pkt_count_q + 16'h0001;
   end
   assign pkt_count_o = pkt_count_q;
`else
   assign pkt_count_o = 16'h0000;
`endif

   assign serdes_data_o = serdes_data_q;
   assign serdes_oe_o   = serdes_oe_q;
   assign lp_p_o        = lp_p_q;
   assign lp_n_o        = lp_n_q;
   assign lp_oe_o       = lp_oe_q;
   assign busy_o        = busy_q;
   assign underrun_o    = underrun_q;

endmodule
